// File: rtl/seq_calculator_if.sv
// Handshake and data bundle between the keypad/display logic and seq_calculator.
// The master drives the request side; the calculator (slave) drives the results.
interface seq_calculator_if #(
   parameter int WIDTH = 7,
   parameter int RES_W = 2*WIDTH
);
   logic             start;
   logic [WIDTH-1:0] in1;
   logic [WIDTH-1:0] in2;
   logic [3:0]       keyboard;
   logic [RES_W-1:0] answer;
   logic             signal;
   logic [WIDTH-1:0] remainder;
   logic             busy;
   logic             done;
   logic             err;

   modport master (
      output start, in1, in2, keyboard,
      input  answer, signal, remainder, busy, done, err
   );

   modport slave (
      input  start, in1, in2, keyboard,
      output answer, signal, remainder, busy, done, err
   );
endinterface

// File: rtl/seq_calculator.sv
// Clocked keypad calculator: single-cycle ADD/SUB/CLR, iterative shift-add MUL
// and restoring DIV, with a start/busy/done handshake and registered results.
module seq_calculator #(
   parameter int WIDTH = 7,
   parameter int RES_W = 2*WIDTH
) (
   input logic             clk,
   input logic             rst_n,
   seq_calculator_if.slave bus
);
   localparam int CNT_W = $clog2(WIDTH + 1);

   localparam logic [3:0] OP_ADD = 4'd10;
   localparam logic [3:0] OP_SUB = 4'd11;
   localparam logic [3:0] OP_MUL = 4'd12;
   localparam logic [3:0] OP_CLR = 4'd13;
   localparam logic [3:0] OP_DIV = 4'd14;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t           state_r,   state_s;
   logic [RES_W-1:0] answer_r,  answer_s;
   logic             signal_r,  signal_s;
   logic [WIDTH-1:0] rem_out_r, rem_out_s;
   logic             busy_r,    busy_s;
   logic             done_r,    done_s;
   logic             err_r,     err_s;
   logic [CNT_W-1:0] cnt_r,     cnt_s;
   logic [RES_W-1:0] acc_r,     acc_s;
   logic [RES_W-1:0] mcand_r,   mcand_s;
   logic [WIDTH-1:0] mplier_r,  mplier_s;
   logic [WIDTH-1:0] divr_r,    divr_s;
   logic [WIDTH-1:0] quo_r,     quo_s;
   logic [WIDTH-1:0] prem_r,    prem_s;

   logic [RES_W-1:0] mul_sum_s;
   logic [WIDTH:0]   div_shift_s;
   logic             div_ge_s;
   logic [WIDTH-1:0] prem_step_s;
   logic [WIDTH-1:0] quo_step_s;
   logic             last_step_s;
   logic             clr_req_s;

   // One shift-add and one restoring-division step computed from the current state.
   always_comb begin
      mul_sum_s   = mplier_r[0] ? (acc_r + mcand_r) : acc_r;
      div_shift_s = {prem_r, quo_r[WIDTH-1]};
      div_ge_s    = (div_shift_s >= {1'b0, divr_r});
      // The partial remainder stays below the divisor, so the low WIDTH bits of the difference are exact.
      prem_step_s = div_ge_s ? (div_shift_s[WIDTH-1:0] - divr_r) : div_shift_s[WIDTH-1:0];
      quo_step_s  = {quo_r[WIDTH-2:0], div_ge_s};
      last_step_s = (cnt_r == CNT_W'(WIDTH - 1));
      clr_req_s   = bus.start && (bus.keyboard == OP_CLR);
   end

   // Next-state and next-output logic of the operation sequencer.
   always_comb begin
      state_s   = state_r;
      answer_s  = answer_r;
      signal_s  = signal_r;
      rem_out_s = rem_out_r;
      busy_s    = busy_r;
      done_s    = 1'b0;
      err_s     = err_r;
      cnt_s     = cnt_r;
      acc_s     = acc_r;
      mcand_s   = mcand_r;
      mplier_s  = mplier_r;
      divr_s    = divr_r;
      quo_s     = quo_r;
      prem_s    = prem_r;

      case (state_r)
         ST_IDLE: begin
            if (bus.start) begin
               case (bus.keyboard)
                  OP_ADD: begin
                     answer_s  = RES_W'(bus.in1) + RES_W'(bus.in2);
                     signal_s  = 1'b0;
                     rem_out_s = '0;
                     err_s     = 1'b0;
                     done_s    = 1'b1;
                     state_s   = ST_DONE;
                  end
                  OP_SUB: begin
                     if (bus.in2 > bus.in1) begin
                        answer_s = RES_W'(bus.in2 - bus.in1);
                        signal_s = 1'b1;
                     end else begin
                        answer_s = RES_W'(bus.in1 - bus.in2);
                        signal_s = 1'b0;
                     end
                     rem_out_s = '0;
                     err_s     = 1'b0;
                     done_s    = 1'b1;
                     state_s   = ST_DONE;
                  end
                  OP_MUL: begin
                     acc_s    = '0;
                     mcand_s  = RES_W'(bus.in1);
                     mplier_s = bus.in2;
                     cnt_s    = '0;
                     busy_s   = 1'b1;
                     state_s  = ST_MUL;
                  end
                  OP_DIV: begin
                     if (bus.in2 != '0) begin
                        quo_s   = bus.in1;
                        divr_s  = bus.in2;
                        prem_s  = '0;
                        cnt_s   = '0;
                        busy_s  = 1'b1;
                        state_s = ST_DIV;
                     end else begin
                        answer_s  = '0;
                        signal_s  = 1'b0;
                        rem_out_s = '0;
                        err_s     = 1'b1;
                        done_s    = 1'b1;
                        state_s   = ST_DONE;
                     end
                  end
                  OP_CLR: begin
                     answer_s  = '0;
                     signal_s  = 1'b0;
                     rem_out_s = '0;
                     err_s     = 1'b0;
                     done_s    = 1'b1;
                     state_s   = ST_DONE;
                  end
                  default: begin
                     err_s   = 1'b1;
                     done_s  = 1'b1;
                     state_s = ST_DONE;
                  end
               endcase
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_MUL, ST_DIV: begin
            if (clr_req_s) begin
               answer_s  = '0;
               signal_s  = 1'b0;
               rem_out_s = '0;
               err_s     = 1'b0;
               busy_s    = 1'b0;
               done_s    = 1'b1;
               state_s   = ST_DONE;
            end else if (state_r == ST_MUL) begin
               acc_s    = mul_sum_s;
               mcand_s  = {mcand_r[RES_W-2:0], 1'b0};
               mplier_s = {1'b0, mplier_r[WIDTH-1:1]};
               cnt_s    = cnt_r + CNT_W'(1);
               if (last_step_s) begin
                  answer_s  = mul_sum_s;
                  signal_s  = 1'b0;
                  rem_out_s = '0;
                  err_s     = 1'b0;
                  busy_s    = 1'b0;
                  done_s    = 1'b1;
                  state_s   = ST_DONE;
               end else begin
                  state_s = ST_MUL;
               end
            end else begin
               quo_s  = quo_step_s;
               prem_s = prem_step_s;
               cnt_s  = cnt_r + CNT_W'(1);
               if (last_step_s) begin
                  answer_s  = RES_W'(quo_step_s);
                  signal_s  = 1'b0;
                  rem_out_s = prem_step_s;
                  err_s     = 1'b0;
                  busy_s    = 1'b0;
                  done_s    = 1'b1;
                  state_s   = ST_DONE;
               end else begin
                  state_s = ST_DIV;
               end
            end
         end
         ST_DONE: begin
            state_s = ST_IDLE;
         end
         default: begin
            busy_s  = 1'b0;
            state_s = ST_IDLE;
         end
      endcase
   end

   // State and result registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         answer_r  <= '0;
         signal_r  <= 1'b0;
         rem_out_r <= '0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         err_r     <= 1'b0;
         cnt_r     <= '0;
         acc_r     <= '0;
         mcand_r   <= '0;
         mplier_r  <= '0;
         divr_r    <= '0;
         quo_r     <= '0;
         prem_r    <= '0;
      end else begin
         state_r   <= state_s;
         answer_r  <= answer_s;
         signal_r  <= signal_s;
         rem_out_r <= rem_out_s;
         busy_r    <= busy_s;
         done_r    <= done_s;
         err_r     <= err_s;
         cnt_r     <= cnt_s;
         acc_r     <= acc_s;
         mcand_r   <= mcand_s;
         mplier_r  <= mplier_s;
         divr_r    <= divr_s;
         quo_r     <= quo_s;
         prem_r    <= prem_s;
      end
   end

   assign bus.answer    = answer_r;
   assign bus.signal    = signal_r;
   assign bus.remainder = rem_out_r;
   assign bus.busy      = busy_r;
   assign bus.done      = done_r;
   assign bus.err       = err_r;
endmodule
